// File: rtl/ad9833_spi_rx.sv
// AD9833 3-wire write receiver: deserialises 16-bit words from sclk/fsync/sdata
// and keeps shadow copies of the control, frequency and phase registers.
module ad9833_spi_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        spi_sclk,
   input  logic        spi_fsync,
   input  logic        spi_sdata,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   output logic        frame_err,
   output logic        busy,
   output logic [15:0] ctrl_reg,
   output logic [27:0] freq0_reg,
   output logic [27:0] freq1_reg,
   output logic [11:0] phase0_reg,
   output logic [11:0] phase1_reg
);

   typedef enum logic {IDLE, SHIFT} state_e;

   logic [2:0]  s_bus;
   logic        s_sclk, s_fsync, s_sdata;
   logic        prev_sclk_q, fall;
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] sh_q, sh_d, data_q, data_d, ctrl_q, ctrl_d;
   logic        vld_q, vld_d, ferr_q, ferr_d;
   logic [27:0] f0_q, f0_d, f1_q, f1_d;
   logic [11:0] p0_q, p0_d, p1_q, p1_d;
   logic        pend_q, pend_d, ptgt_q, ptgt_d;
   logic [15:0] word;
   logic        done, tgt, msb;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s_bus = {spi_sclk, spi_fsync, spi_sdata};
      end else begin : g_sync
         logic [2:0] sync_q [SYNC_STAGES];
         // Flops reset to the idle bus level so release never fakes an edge
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b111;
            end else begin
               sync_q[0] <= {spi_sclk, spi_fsync, spi_sdata};
               for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
         end
         assign s_bus = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   assign {s_sclk, s_fsync, s_sdata} = s_bus;
   assign fall = prev_sclk_q & ~s_sclk;
   assign word = {sh_q[14:0], s_sdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_sclk_q <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         data_q      <= '0;
         vld_q       <= 1'b0;
         ferr_q      <= 1'b0;
         ctrl_q      <= '0;
         f0_q        <= '0;
         f1_q        <= '0;
         p0_q        <= '0;
         p1_q        <= '0;
         pend_q      <= 1'b0;
         ptgt_q      <= 1'b0;
      end else begin
         prev_sclk_q <= s_sclk;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         data_q      <= data_d;
         vld_q       <= vld_d;
         ferr_q      <= ferr_d;
         ctrl_q      <= ctrl_d;
         f0_q        <= f0_d;
         f1_q        <= f1_d;
         p0_q        <= p0_d;
         p1_q        <= p1_d;
         pend_q      <= pend_d;
         ptgt_q      <= ptgt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      data_d  = data_q;
      vld_d   = 1'b0;
      ferr_d  = 1'b0;
      ctrl_d  = ctrl_q;
      f0_d    = f0_q;
      f1_d    = f1_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      pend_d  = pend_q;
      ptgt_d  = ptgt_q;
      done    = 1'b0;
      tgt     = word[15];
      msb     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!s_fsync) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (fall) begin
               sh_d  = word;
               cnt_d = cnt_q + 4'd1;
               done  = (cnt_q == 4'hF);
            end
            // A coincident fall is counted before judging the frame end
            if (s_fsync) begin
               state_d = IDLE;
               ferr_d  = (cnt_d != 4'd0);
               cnt_d   = '0;
            end
         end
      endcase
      if (done) begin
         data_d = word;
         vld_d  = 1'b1;
         unique case (word[15:14])
            2'b00: begin
               ctrl_d = word;
               pend_d = 1'b0;
            end
            2'b01, 2'b10: begin
               if (ctrl_q[13]) begin
                  msb    = pend_q && (ptgt_q == tgt);
                  pend_d = !msb;
                  ptgt_d = tgt;
               end else begin
                  msb    = ctrl_q[12];
                  pend_d = 1'b0;
               end
               if (tgt) begin
                  if (msb) f1_d[27:14] = word[13:0];
                  else     f1_d[13:0]  = word[13:0];
               end else begin
                  if (msb) f0_d[27:14] = word[13:0];
                  else     f0_d[13:0]  = word[13:0];
               end
            end
            2'b11: begin
               if (word[13]) p1_d = word[11:0];
               else          p0_d = word[11:0];
            end
         endcase
      end
   end

   assign rx_data    = data_q;
   assign rx_valid   = vld_q;
   assign frame_err  = ferr_q;
   assign busy       = ~s_fsync;
   assign ctrl_reg   = ctrl_q;
   assign freq0_reg  = f0_q;
   assign freq1_reg  = f1_q;
   assign phase0_reg = p0_q;
   assign phase1_reg = p1_q;

endmodule

// File: tb/tb_ad9833_spi_rx.sv
// Scoreboard bench for ad9833_spi_rx: words queued as they are shifted in,
// checked (data and latency) when rx_valid fires; shadows checked after frames.
module tb_ad9833_spi_rx;

   logic        clk, rst_n;
   logic        spi_sclk, spi_fsync, spi_sdata;
   logic [15:0] rx_data;
   logic        rx_valid, frame_err, busy;
   logic [15:0] ctrl_reg;
   logic [27:0] freq0_reg, freq1_reg;
   logic [11:0] phase0_reg, phase1_reg;

   typedef struct {
      logic [15:0] d;
      int          c;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0, n_rx = 0, n_ferr = 0;
   int   rx0, fe0;

   ad9833_spi_rx #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_sclk(spi_sclk), .spi_fsync(spi_fsync), .spi_sdata(spi_sdata),
      .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
      .busy(busy), .ctrl_reg(ctrl_reg),
      .freq0_reg(freq0_reg), .freq1_reg(freq1_reg),
      .phase0_reg(phase0_reg), .phase1_reg(phase1_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rx_valid) begin
         n_rx++;
         if (sbq.size() == 0) begin
            check("rx_unexpected", 64'(rx_data), 64'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("rx_data", 64'(rx_data), 64'(e.d));
            check("rx_latency", 64'(cyc), 64'(e.c));
         end
      end
      if (rst_n && frame_err) n_ferr++;
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Shift the top nbits of w; the 16th fall queues the word
   task automatic xfer(input logic [15:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         spi_sdata = w[15-i];
         wait_n(1);
         spi_sclk = 1'b0;
         if (i == 15) sbq.push_back('{w, cyc + 3});
         wait_n(2);
         spi_sclk = 1'b1;
         wait_n(1);
      end
   endtask

   task automatic fs_lo();
      spi_fsync = 1'b0;
      wait_n(2);
   endtask

   task automatic fs_hi();
      wait_n(2);
      spi_fsync = 1'b1;
      wait_n(40);
   endtask

   task automatic frame(input logic [15:0] w);
      fs_lo();
      xfer(w, 16);
      fs_hi();
   endtask

   initial begin
      rst_n = 1'b0;
      spi_sclk = 1'b1;
      spi_fsync = 1'b1;
      spi_sdata = 1'b0;
      wait_n(4);
      check("rst_low", {rx_data, rx_valid, frame_err, busy, ctrl_reg, 29'd0},
            64'd0);
      check("rst_freq", {8'd0, freq0_reg, freq1_reg}, 64'd0);
      check("rst_phase", {40'd0, phase0_reg, phase1_reg}, 64'd0);
      rst_n = 1'b1;
      wait_n(4);

      rx0 = n_rx;
      fs_lo();
      check("busy", 64'(busy), 64'd1);
      xfer(16'h2100, 16);
      fs_hi();
      check("busy_idle", 64'(busy), 64'd0);
      check("rx_once", 64'(n_rx - rx0), 64'd1);
      check("ctrl_2100", 64'(ctrl_reg), 64'h2100);

      frame(16'h50C7);
      check("f0_lsb", 64'(freq0_reg), 64'h00010C7);
      frame(16'h4000);
      check("f0_b28", 64'(freq0_reg), 64'h00010C7);
      frame(16'h4005);
      check("pend_clr", 64'(freq0_reg), 64'h0000005);

      frame(16'h0000);
      frame(16'h8123);
      check("f1_lo", 64'(freq1_reg), 64'h0000123);
      frame(16'h1000);
      check("ctrl_hlb", 64'(ctrl_reg), 64'h1000);
      frame(16'h8ABC);
      check("f1_hlb", 64'(freq1_reg), {36'd0, 14'h0ABC, 14'h0123});

      rx0 = n_rx;
      fs_lo();
      xfer(16'hC123, 16);
      xfer(16'hE456, 16);
      fs_hi();
      check("rx_two", 64'(n_rx - rx0), 64'd2);
      check("phase0", 64'(phase0_reg), 64'h123);
      check("phase1", 64'(phase1_reg), 64'h456);

      rx0 = n_rx;
      fe0 = n_ferr;
      fs_lo();
      xfer(16'hFFFF, 9);
      fs_hi();
      check("ferr_once", 64'(n_ferr - fe0), 64'd1);
      check("ferr_no_rx", 64'(n_rx - rx0), 64'd0);
      frame(16'h0000);
      check("after_err_rx", 64'(n_rx - rx0), 64'd1);
      check("after_err_ctrl", 64'(ctrl_reg), 64'h0000);
      check("after_err_f1", 64'(freq1_reg), {36'd0, 14'h0ABC, 14'h0123});

      fe0 = n_ferr;
      fs_lo();
      xfer(16'h5555, 8);
      rst_n = 1'b0;
      #1;
      check("mid_rst_low",
            {rx_data, rx_valid, frame_err, busy, ctrl_reg, 29'd0}, 64'd0);
      check("mid_rst_freq", {8'd0, freq0_reg, freq1_reg}, 64'd0);
      check("mid_rst_phase", {40'd0, phase0_reg, phase1_reg}, 64'd0);
      spi_fsync = 1'b1;
      wait_n(4);
      rst_n = 1'b1;
      wait_n(6);
      rx0 = n_rx;
      frame(16'h2000);
      check("post_rst_rx", 64'(n_rx - rx0), 64'd1);
      check("post_rst_data", 64'(rx_data), 64'h2000);
      check("post_rst_ferr", 64'(n_ferr - fe0), 64'd0);
      check("sb_drain", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
